// File: rtl/pipelined_reduce_gate_pkg.sv
// Shared op encodings and group-reduction helper for the pipelined reduce gate.
package pipelined_reduce_gate_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;

    // Upper bound on a leaf group; callers zero-extend their group into this width.
    localparam int MAX_GROUP_SIZE = 64;

    function automatic logic op_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic [2:0] reduce_group(input logic [MAX_GROUP_SIZE-1:0] vec,
                                                input int width);
        logic and_acc;
        logic or_acc;
        logic xor_acc;
        and_acc = 1'b1;
        or_acc  = 1'b0;
        xor_acc = 1'b0;
        for (int i = 0; i < MAX_GROUP_SIZE; i++) begin
            if (i < width) begin
                and_acc = and_acc & vec[i];
                or_acc  = or_acc  | vec[i];
                xor_acc = xor_acc ^ vec[i];
            end
        end
        return {and_acc, or_acc, xor_acc};
    endfunction

endpackage

// File: rtl/pipelined_reduce_gate_leaf.sv
// Combinational AND/OR/XOR of one GROUP_SIZE-bit leaf group.
module reduce_group_leaf
    import pipelined_reduce_gate_pkg::*;
#(
    parameter int GROUP_SIZE = 8
) (
    input  logic [GROUP_SIZE-1:0] i_vec,
    output logic                  o_and,
    output logic                  o_or,
    output logic                  o_xor
);

    logic [MAX_GROUP_SIZE-1:0] w_padded;

    assign w_padded              = MAX_GROUP_SIZE'(i_vec);
    assign {o_and, o_or, o_xor}  = reduce_group(w_padded, GROUP_SIZE);

endmodule

// File: rtl/pipelined_reduce_gate.sv
// Two-stage registered reduction tree with valid/ready handshake and result counters.
module pipelined_reduce_gate
    import pipelined_reduce_gate_pkg::*;
#(
    parameter int                      NR_OF_INPUTS = 32,
    parameter int                      GROUP_SIZE   = 8,
    parameter logic [NR_OF_INPUTS-1:0] BUBBLES_MASK = '0,
    parameter int                      COUNT_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NR_OF_INPUTS-1:0] in_data,
    input  logic [NR_OF_INPUTS-1:0] in_mask,
    input  logic [2:0]              in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_result,
    output logic                    out_illegal,
    output logic [COUNT_WIDTH-1:0]  res_count,
    output logic [COUNT_WIDTH-1:0]  ones_count
);

    localparam int NR_GROUPS = NR_OF_INPUTS / GROUP_SIZE;

    logic [NR_OF_INPUTS-1:0] w_eff;
    logic [NR_GROUPS-1:0]    w_grp_and;
    logic [NR_GROUPS-1:0]    w_grp_or;
    logic [NR_GROUPS-1:0]    w_grp_xor;
    logic                    w_s2_ready;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_advance;
    logic                    w_drain;
    logic                    w_next_result;
    logic                    w_next_illegal;

    logic                    r_s1_valid;
    logic [NR_GROUPS-1:0]    r_s1_and;
    logic [NR_GROUPS-1:0]    r_s1_or;
    logic [NR_GROUPS-1:0]    r_s1_xor;
    logic [2:0]              r_s1_op;
    logic                    r_out_valid;
    logic                    r_out_result;
    logic                    r_out_illegal;
    logic [COUNT_WIDTH-1:0]  r_res_count;
    logic [COUNT_WIDTH-1:0]  r_ones_count;

    assign w_eff = in_data ^ in_mask ^ BUBBLES_MASK;

    for (genvar g = 0; g < NR_GROUPS; g++) begin : g_leaf
        reduce_group_leaf #(
            .GROUP_SIZE (GROUP_SIZE)
        ) u_leaf (
            .i_vec (w_eff[g*GROUP_SIZE +: GROUP_SIZE]),
            .o_and (w_grp_and[g]),
            .o_or  (w_grp_or[g]),
            .o_xor (w_grp_xor[g])
        );
    end

    // No skid buffer: in_ready ripples combinationally from out_ready.
    assign w_s2_ready = !r_out_valid | out_ready;
    assign w_in_ready = !r_s1_valid | w_s2_ready;
    assign w_accept   = in_valid & w_in_ready;
    assign w_advance  = r_s1_valid & w_s2_ready;
    assign w_drain    = r_out_valid & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_and   <= '0;
            r_s1_or    <= '0;
            r_s1_xor   <= '0;
            r_s1_op    <= OP_AND;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_and   <= w_grp_and;
            r_s1_or    <= w_grp_or;
            r_s1_xor   <= w_grp_xor;
            r_s1_op    <= in_op;
        end else if (w_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_comb begin
        w_next_result  = 1'b0;
        w_next_illegal = op_illegal(r_s1_op);
        case (r_s1_op)
            OP_AND:  w_next_result = &r_s1_and;
            OP_NAND: w_next_result = ~(&r_s1_and);
            OP_OR:   w_next_result = |r_s1_or;
            OP_NOR:  w_next_result = ~(|r_s1_or);
            OP_XOR:  w_next_result = ^r_s1_xor;
            OP_XNOR: w_next_result = ~(^r_s1_xor);
            default: w_next_result = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= 1'b0;
            r_out_illegal <= 1'b0;
        end else if (w_advance) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= w_next_result;
            r_out_illegal <= w_next_illegal;
        end else if (w_drain) begin
            r_out_valid   <= 1'b0;
        end
    end

    // Illegal results return 0, so they never bump ones_count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_res_count  <= '0;
            r_ones_count <= '0;
        end else if (w_drain) begin
            r_res_count <= r_res_count + COUNT_WIDTH'(1);
            if (r_out_result) begin
                r_ones_count <= r_ones_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_illegal = r_out_illegal;
    assign res_count   = r_res_count;
    assign ones_count  = r_ones_count;

endmodule

// File: tb/tb_pipelined_reduce_gate.sv
// Scoreboard bench: directed vectors push expected results; monitors pop on each output transfer.
module tb_pipelined_reduce_gate;

    localparam logic [2:0] AND_OP  = 3'b000;
    localparam logic [2:0] NAND_OP = 3'b001;
    localparam logic [2:0] OR_OP   = 3'b010;
    localparam logic [2:0] NOR_OP  = 3'b011;
    localparam logic [2:0] XOR_OP  = 3'b100;
    localparam logic [2:0] XNOR_OP = 3'b101;
    localparam logic [2:0] ILL_OP  = 3'b110;

    logic        clock = 1'b0;
    logic        reset_n;

    logic        aInValid, aInReady, aOutValid, aOutReady, aOutResult, aOutIllegal;
    logic [31:0] aInData, aInMask;
    logic [2:0]  aInOp;
    logic [15:0] aResCount, aOnesCount;

    logic        bInValid, bInReady, bOutValid, bOutReady, bOutResult, bOutIllegal;
    logic [31:0] bInData, bInMask;
    logic [2:0]  bInOp;
    logic [3:0]  bResCount, bOnesCount;

    logic [1:0]  qA[$];
    logic [1:0]  qB[$];
    logic [1:0]  eA, eB;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    pipelined_reduce_gate u_dutA (
        .clock(clock), .reset_n(reset_n),
        .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData), .in_mask(aInMask), .in_op(aInOp),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_result(aOutResult), .out_illegal(aOutIllegal),
        .res_count(aResCount), .ones_count(aOnesCount)
    );

    pipelined_reduce_gate #(
        .BUBBLES_MASK (32'h0000_0001),
        .COUNT_WIDTH  (4)
    ) u_dutB (
        .clock(clock), .reset_n(reset_n),
        .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData), .in_mask(bInMask), .in_op(bInOp),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_result(bOutResult), .out_illegal(bOutIllegal),
        .res_count(bResCount), .ones_count(bOnesCount)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && aOutValid && aOutReady) begin
            if (qA.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL A_unexpected: got result %0b expected no output", aOutResult);
            end else begin
                eA = qA.pop_front();
                checkOutput("A_result", 32'(aOutResult), 32'(eA[1]));
                checkOutput("A_illegal", 32'(aOutIllegal), 32'(eA[0]));
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n && bOutValid && bOutReady) begin
            if (qB.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL B_unexpected: got result %0b expected no output", bOutResult);
            end else begin
                eB = qB.pop_front();
                checkOutput("B_result", 32'(bOutResult), 32'(eB[1]));
                checkOutput("B_illegal", 32'(bOutIllegal), 32'(eB[0]));
            end
        end
    end

    task automatic applyStimulusA(input logic [31:0] d, input logic [31:0] m, input logic [2:0] op,
                                  input logic r, input logic il);
        bit acc = 0;
        int n = 0;
        aInData = d; aInMask = m; aInOp = op; aInValid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clock);
            acc = aInReady;
            @(posedge clock);
            #1;
            n++;
        end
        if (acc) qA.push_back({r, il});
        else checkOutput("A_accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic applyStimulusB(input logic [31:0] d, input logic [31:0] m, input logic [2:0] op,
                                  input logic r, input logic il);
        bit acc = 0;
        int n = 0;
        bInData = d; bInMask = m; bInOp = op; bInValid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clock);
            acc = bInReady;
            @(posedge clock);
            #1;
            n++;
        end
        if (acc) qB.push_back({r, il});
        else checkOutput("B_accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drainA();
        int n = 0;
        aInValid = 1'b0;
        while (qA.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        checkOutput("A_drain_left", qA.size(), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic drainB();
        int n = 0;
        bInValid = 1'b0;
        while (qB.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        checkOutput("B_drain_left", qB.size(), 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        aInValid = 0; aInData = 0; aInMask = 0; aInOp = 0; aOutReady = 1;
        bInValid = 0; bInData = 0; bInMask = 0; bInOp = 0; bOutReady = 1;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("rst_in_ready", 32'(aInReady), 1);
        checkOutput("rst_out_valid", 32'(aOutValid), 0);
        checkOutput("rst_out_result", 32'(aOutResult), 0);
        checkOutput("rst_out_illegal", 32'(aOutIllegal), 0);
        checkOutput("rst_res_count", 32'(aResCount), 0);
        checkOutput("rst_ones_count", 32'(aOnesCount), 0);
        @(posedge clock);
        #1;

        // Zero-detect, masks, every op on a corner operand, then an illegal op.
        applyStimulusA(32'h0000_0000, 32'h0, NOR_OP, 1'b1, 1'b0);
        applyStimulusA(32'h0000_0100, 32'h0, NOR_OP, 1'b0, 1'b0);
        applyStimulusA(32'hFFFF_FFFF, 32'hFFFF_FFFF, NOR_OP, 1'b1, 1'b0);
        applyStimulusA(32'h8000_0001, 32'h0, AND_OP,  1'b0, 1'b0);
        applyStimulusA(32'h8000_0001, 32'h0, NAND_OP, 1'b1, 1'b0);
        applyStimulusA(32'h8000_0001, 32'h0, OR_OP,   1'b1, 1'b0);
        applyStimulusA(32'h8000_0001, 32'h0, NOR_OP,  1'b0, 1'b0);
        applyStimulusA(32'h8000_0001, 32'h0, XOR_OP,  1'b0, 1'b0);
        applyStimulusA(32'h8000_0001, 32'h0, XNOR_OP, 1'b1, 1'b0);
        applyStimulusA(32'h8000_0001, 32'h0, ILL_OP,  1'b0, 1'b1);
        drainA();
        checkOutput("s1_res_count", 32'(aResCount), 10);
        checkOutput("s1_ones_count", 32'(aOnesCount), 5);

        reset_n = 1'b0;
        #1;
        checkOutput("rst2_res_count", 32'(aResCount), 0);
        checkOutput("rst2_ones_count", 32'(aOnesCount), 0);
        qA.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Backpressure: first result is 1 and must hold while out_ready is low.
        aOutReady = 1'b0;
        fork
            begin
                applyStimulusA(32'h0000_0000, 32'h0, NOR_OP, 1'b1, 1'b0);
                applyStimulusA(32'h0000_0100, 32'h0, NOR_OP, 1'b0, 1'b0);
                applyStimulusA(32'h0000_000F, 32'h0, AND_OP, 1'b0, 1'b0);
                applyStimulusA(32'hFFFF_FFFF, 32'h0, AND_OP, 1'b1, 1'b0);
                applyStimulusA(32'h0000_0003, 32'h0, XOR_OP, 1'b0, 1'b0);
                aInValid = 1'b0;
            end
            begin
                repeat (2) @(posedge clock);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clock);
                    checkOutput("bp_in_ready", 32'(aInReady), 0);
                    checkOutput("bp_hold_valid", 32'(aOutValid), 1);
                    checkOutput("bp_hold_result", 32'(aOutResult), 1);
                end
                @(posedge clock);
                #1;
                aOutReady = 1'b1;
            end
        join
        drainA();
        checkOutput("bp_res_count", 32'(aResCount), 5);
        checkOutput("bp_ones_count", 32'(aOnesCount), 2);

        // Fill both stages, then reset asynchronously between edges.
        aOutReady = 1'b0;
        aInData = 32'h0; aInMask = 32'h0; aInOp = NOR_OP; aInValid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        aInValid = 1'b0;
        checkOutput("mid_full_valid", 32'(aOutValid), 1);
        checkOutput("mid_full_in_ready", 32'(aInReady), 0);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_out_valid", 32'(aOutValid), 0);
        checkOutput("async_res_count", 32'(aResCount), 0);
        checkOutput("async_ones_count", 32'(aOnesCount), 0);
        checkOutput("async_in_ready", 32'(aInReady), 1);
        qA.delete();
        aOutReady = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        checkOutput("post_reset_valid", 32'(aOutValid), 0);
        checkOutput("post_reset_count", 32'(aResCount), 0);

        // Narrow counters wrap; bit 0 is statically inverted on this instance.
        for (int i = 0; i < 17; i++) applyStimulusB(32'h0000_0001, 32'h0, NOR_OP, 1'b1, 1'b0);
        drainB();
        checkOutput("wrap_res_count", 32'(bResCount), 1);
        checkOutput("wrap_ones_count", 32'(bOnesCount), 1);
        applyStimulusB(32'h0000_0000, 32'h0, NOR_OP, 1'b0, 1'b0);
        drainB();
        checkOutput("bubble_res_count", 32'(bResCount), 2);
        checkOutput("bubble_ones_count", 32'(bOnesCount), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
